// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader: assembles a length-prefixed big-endian
// byte stream into 32-bit words, writes them sequentially, then releases the CPU.
module inst_mem_loader #(
  parameter int ADDR_WORDS_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        start,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WORDS_LOG2;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_LAST,
    S_DONE,
    S_ERR
  } state_t;

  state_t                     state, state_nx;
  logic [7:0]                 len_hi;
  logic [15:0]                len;
  logic [ADDR_WORDS_LOG2-1:0] word_index;
  logic [1:0]                 byte_cnt;
  logic [23:0]                asm_q;

  logic        take;
  logic [15:0] len_in;
  logic        len_too_big;
  logic        last_word;

  assign take        = in_valid && in_ready;
  assign len_in      = {len_hi, in_byte};
  assign len_too_big = 32'(len_in) > DEPTH;
  // len is at least 1 in DATA, so len-1 cannot underflow.
  assign last_word   = 32'(word_index) == (32'(len) - 32'd1);

  // Status outputs decode straight from state so an async reset moves them at once.
  assign cpu_hold = (state != S_DONE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LEN_HI;
    else       state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (take) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (take) begin
          if (len_in == 16'd0) state_nx = S_DONE;
          else if (len_too_big) state_nx = S_ERR;
          else                  state_nx = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (take && byte_cnt == 2'd3 && last_word) state_nx = S_LAST;
      end
      S_LAST:  state_nx = S_DONE;
      S_DONE:  if (start) state_nx = S_LEN_HI;
      S_ERR:   if (start) state_nx = S_LEN_HI;
      default: state_nx = S_LEN_HI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi     <= '0;
      len        <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (take) begin
        case (state)
          S_LEN_HI: len_hi <= in_byte;
          S_LEN_LO: begin
            len        <= len_in;
            word_index <= '0;
            byte_cnt   <= '0;
          end
          S_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_wdata <= {asm_q, in_byte};
              mem_addr  <= 32'({word_index, 2'b00});
              mem_we    <= 1'b1;
              if (!last_word) word_index <= word_index + 1'b1;
            end else begin
              asm_q <= {asm_q[15:0], in_byte};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: a cycle-by-cycle vector table for the
// full-rate, zero-length and oversize cases, then hand-written multi-cycle sequences.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        start;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        vld;
    logic [7:0]  b;
    logic        st;
    logic        rdy;
    logic        we;
    logic        dn;
    logic        hold;
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  writes[$];

  inst_mem_loader #(.ADDR_WORDS_LOG2(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Each strobe is one cycle wide, so a longer pulse shows up as a duplicate record.
  always @(negedge clk) begin
    if (mem_we) writes.push_back('{addr: mem_addr, data: mem_wdata});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic vld, input logic [7:0] b, input logic st,
                             input logic rdy, input logic we, input logic dn,
                             input logic hold, input logic err,
                             input logic [31:0] addr, input logic [31:0] data);
    vec_t r;
    r.vld = vld; r.b = b; r.st = st;
    r.rdy = rdy; r.we = we; r.dn = dn; r.hold = hold; r.err = err;
    r.addr = addr; r.data = data;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte after `gap` idle cycles; returns one step after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit accepted = 0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 20 && !accepted; t++) begin
      if (in_ready) accepted = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!accepted) check("send_byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] stall_bytes [6];
    logic [7:0] fresh_bytes [6];
    logic [7:0] reload_bytes[6];
    stall_bytes  = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    fresh_bytes  = '{8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    reload_bytes = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};

    // Outputs listed are those seen during the cycle in which the inputs are applied.
    //            vld  byte   st   rdy  we   dn   hold err  addr        data
    vecs.push_back(v(1, 8'h00, 0,  1,   0,   0,   1,   0,  32'h0, 32'h0));
    vecs.push_back(v(1, 8'h03, 0,  1,   0,   0,   1,   0,  32'h0, 32'h0));
    vecs.push_back(v(1, 8'h20, 0,  1,   0,   0,   1,   0,  32'h0, 32'h0));
    vecs.push_back(v(1, 8'h04, 0,  1,   0,   0,   1,   0,  32'h0, 32'h0));
    vecs.push_back(v(1, 8'h30, 0,  1,   0,   0,   1,   0,  32'h0, 32'h0));
    vecs.push_back(v(1, 8'h39, 0,  1,   0,   0,   1,   0,  32'h0, 32'h0));
    vecs.push_back(v(1, 8'h24, 0,  1,   1,   0,   1,   0,  32'h0, 32'h20043039));
    vecs.push_back(v(1, 8'h05, 0,  1,   0,   0,   1,   0,  32'h0, 32'h20043039));
    vecs.push_back(v(1, 8'hD4, 0,  1,   0,   0,   1,   0,  32'h0, 32'h20043039));
    vecs.push_back(v(1, 8'h31, 0,  1,   0,   0,   1,   0,  32'h0, 32'h20043039));
    vecs.push_back(v(1, 8'h00, 0,  1,   1,   0,   1,   0,  32'h4, 32'h2405D431));
    vecs.push_back(v(1, 8'h05, 0,  1,   0,   0,   1,   0,  32'h4, 32'h2405D431));
    vecs.push_back(v(1, 8'h34, 0,  1,   0,   0,   1,   0,  32'h4, 32'h2405D431));
    vecs.push_back(v(1, 8'h00, 0,  1,   0,   0,   1,   0,  32'h4, 32'h2405D431));
    vecs.push_back(v(0, 8'h00, 0,  0,   1,   0,   1,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(0, 8'h00, 0,  0,   0,   1,   0,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(1, 8'hFF, 0,  0,   0,   1,   0,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(0, 8'h00, 1,  0,   0,   1,   0,   0,  32'h8, 32'h00053400));
    // zero length image
    vecs.push_back(v(1, 8'h00, 0,  1,   0,   0,   1,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(1, 8'h00, 0,  1,   0,   0,   1,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(0, 8'h00, 0,  0,   0,   1,   0,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(0, 8'h00, 1,  0,   0,   1,   0,   0,  32'h8, 32'h00053400));
    // N=257 overflows a 256-word memory
    vecs.push_back(v(1, 8'h01, 0,  1,   0,   0,   1,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(1, 8'h01, 0,  1,   0,   0,   1,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(1, 8'h00, 0,  0,   0,   0,   1,   1,  32'h8, 32'h00053400));
    vecs.push_back(v(0, 8'h00, 1,  0,   0,   0,   1,   1,  32'h8, 32'h00053400));
    // N=256 is exactly the depth and must be accepted
    vecs.push_back(v(1, 8'h01, 0,  1,   0,   0,   1,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(1, 8'h00, 0,  1,   0,   0,   1,   0,  32'h8, 32'h00053400));
    vecs.push_back(v(0, 8'h00, 0,  1,   0,   0,   1,   0,  32'h8, 32'h00053400));

    reset    = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    start    = 1'b0;
    tick();
    tick();
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_mem_we",    32'(mem_we),    32'd0);
    check("reset_mem_addr",  mem_addr,       32'h0);
    check("reset_mem_wdata", mem_wdata,      32'h0);
    check("reset_cpu_hold",  32'(cpu_hold),  32'd1);
    check("reset_done",      32'(done),      32'd0);
    check("reset_error",     32'(error),     32'd0);
    reset = 1'b0;
    writes.delete();

    foreach (vecs[i]) begin
      in_valid = vecs[i].vld;
      in_byte  = vecs[i].b;
      start    = vecs[i].st;
      check($sformatf("vec%0d_in_ready", i),  32'(in_ready), 32'(vecs[i].rdy));
      check($sformatf("vec%0d_mem_we", i),    32'(mem_we),   32'(vecs[i].we));
      check($sformatf("vec%0d_done", i),      32'(done),     32'(vecs[i].dn));
      check($sformatf("vec%0d_cpu_hold", i),  32'(cpu_hold), 32'(vecs[i].hold));
      check($sformatf("vec%0d_error", i),     32'(error),    32'(vecs[i].err));
      check($sformatf("vec%0d_mem_addr", i),  mem_addr,      vecs[i].addr);
      check($sformatf("vec%0d_mem_wdata", i), mem_wdata,     vecs[i].data);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("table_write_count", 32'(writes.size()), 32'd3);

    // Reset in the middle of a word (loader is in DATA of the N=256 image).
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #3;
    reset = 1'b1;
    #1;
    check("midreset_mem_we",   32'(mem_we),   32'd0);
    check("midreset_cpu_hold", 32'(cpu_hold), 32'd1);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_mem_addr", mem_addr,      32'h0);
    tick();
    reset = 1'b0;
    writes.delete();
    foreach (fresh_bytes[i]) send_byte(fresh_bytes[i], 0);
    check("fresh_mem_we",    32'(mem_we), 32'd1);
    check("fresh_mem_addr",  mem_addr,    32'h0);
    check("fresh_mem_wdata", mem_wdata,   32'hA1B2C3D4);
    check("fresh_done_early", 32'(done),  32'd0);
    tick();
    check("fresh_done",     32'(done),     32'd1);
    check("fresh_cpu_hold", 32'(cpu_hold), 32'd0);
    check("fresh_mem_we_1cycle", 32'(mem_we), 32'd0);
    check("fresh_write_count", 32'(writes.size()), 32'd1);

    // Stalled stream with random gaps, then bytes held while not ready.
    pulse_start();
    check("stall_in_ready", 32'(in_ready), 32'd1);
    check("stall_cpu_hold", 32'(cpu_hold), 32'd1);
    writes.delete();
    foreach (stall_bytes[i]) send_byte(stall_bytes[i], int'($urandom_range(0, 5)));
    tick();
    check("stall_done", 32'(done), 32'd1);
    in_valid = 1'b1;
    in_byte  = 8'hEE;
    for (int i = 0; i < 5; i++) tick();
    check("stall_held_in_ready", 32'(in_ready), 32'd0);
    check("stall_held_done",     32'(done),     32'd1);
    in_valid = 1'b0;
    check("stall_write_count", 32'(writes.size()), 32'd1);
    if (writes.size() == 1) begin
      check("stall_wr_addr", writes[0].addr, 32'h0);
      check("stall_wr_data", writes[0].data, 32'hAABBCCDD);
    end

    // Reload at full rate.
    pulse_start();
    check("reload_cpu_hold", 32'(cpu_hold), 32'd1);
    check("reload_done",     32'(done),     32'd0);
    writes.delete();
    foreach (reload_bytes[i]) send_byte(reload_bytes[i], 0);
    check("reload_mem_we",    32'(mem_we), 32'd1);
    check("reload_mem_wdata", mem_wdata,   32'h12345678);
    tick();
    check("reload_done_after", 32'(done),     32'd1);
    check("reload_released",   32'(cpu_hold), 32'd0);
    check("reload_write_count", 32'(writes.size()), 32'd1);
    if (writes.size() == 1) begin
      check("reload_wr_addr", writes[0].addr, 32'h0);
      check("reload_wr_data", writes[0].data, 32'h12345678);
    end

    // Asynchronous reset while released must drop done at once.
    #3;
    reset = 1'b1;
    #1;
    check("donereset_done",     32'(done),     32'd0);
    check("donereset_cpu_hold", 32'(cpu_hold), 32'd1);
    check("donereset_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
